// File: rtl/array_scan_pkg.sv
// Shared types and width helpers for the array scan engine.
package array_scan_pkg;

  typedef enum logic [1:0] {
    INDEX         = 2'd0,
    COUNT_LESS    = 2'd1,
    COUNT_GREATER = 2'd2,
    COUNT_EQUAL   = 2'd3
  } scan_mode_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    READ   = 2'd1,
    DRAIN  = 2'd2,
    FINISH = 2'd3
  } scan_state_t;

  function automatic int addr_width(input int narrays, input int narea);
    return (narrays * narea > 1) ? $clog2(narrays * narea) : 1;
  endfunction

  function automatic int size_width(input int narea);
    return $clog2(narea + 1);
  endfunction

  function automatic int result_width(input int narea);
    return $clog2(narea + 1);
  endfunction

  function automatic int lane_width(input int lanes);
    return (lanes > 1) ? $clog2(lanes) : 1;
  endfunction

  function automatic int count_width(input int lanes);
    return $clog2(lanes + 1);
  endfunction

endpackage

// File: rtl/array_scan_lane_cmp.sv
// Compares one beat of heap data against the key: match count, any-match and
// the lowest matching valid lane.
module array_scan_lane_cmp
  import array_scan_pkg::*;
#(
  parameter int WIDTH = 12,
  parameter int LANES = 1
) (
  input  logic [LANES*WIDTH-1:0]           i_data,
  input  logic [LANES-1:0]                 i_valid,
  input  logic [WIDTH-1:0]                 i_key,
  input  scan_mode_t                       i_mode,
  output logic [count_width(LANES)-1:0]    o_count,
  output logic                             o_any,
  output logic [lane_width(LANES)-1:0]     o_first
);

  localparam int CW = count_width(LANES);
  localparam int LW = lane_width(LANES);

  logic [LANES-1:0] w_hit;

  // per-lane unsigned compare, masked by the live-element mask
  always_comb begin
    w_hit = '0;
    for (int k = 0; k < LANES; k++) begin
      case (i_mode)
        INDEX, COUNT_EQUAL: w_hit[k] = (i_data[k*WIDTH +: WIDTH] == i_key) & i_valid[k];
        COUNT_LESS:         w_hit[k] = (i_data[k*WIDTH +: WIDTH] <  i_key) & i_valid[k];
        COUNT_GREATER:      w_hit[k] = (i_data[k*WIDTH +: WIDTH] >  i_key) & i_valid[k];
        default:            w_hit[k] = 1'b0;
      endcase
    end
  end

  // population count and priority pick (lowest lane wins)
  always_comb begin
    o_count = '0;
    o_first = '0;
    for (int k = LANES - 1; k >= 0; k--) begin
      o_count = o_count + CW'(w_hit[k]);
      o_first = w_hit[k] ? LW'(k) : o_first;
    end
  end

  assign o_any = |w_hit;

endmodule

// File: rtl/array_scan_unit.sv
// Multi-cycle array scan engine: index-of and count-less/greater/equal over the
// live elements of one heap array, LANES elements per read beat.
module array_scan_unit
  import array_scan_pkg::*;
#(
  parameter int WIDTH   = 12,
  parameter int NAREA   = 4,
  parameter int NARRAYS = 20,
  parameter int LANES   = 1
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic                                 start,
  input  logic [1:0]                           mode,
  input  logic [$clog2(NARRAYS)-1:0]           array,
  input  logic [size_width(NAREA)-1:0]         size,
  input  logic [WIDTH-1:0]                     key,
  output logic                                 mem_rd,
  output logic [addr_width(NARRAYS,NAREA)-1:0] mem_addr,
  input  logic [LANES*WIDTH-1:0]               mem_data,
  output logic                                 busy,
  output logic                                 done,
  output logic [result_width(NAREA)-1:0]       result
);

  localparam int AW = addr_width(NARRAYS, NAREA);
  localparam int SW = size_width(NAREA);
  localparam int RW = result_width(NAREA);
  localparam int CW = count_width(LANES);
  localparam int LW = lane_width(LANES);
  localparam int EW = $clog2(NAREA + LANES + 1);

  scan_state_t    r_state;
  scan_mode_t     r_mode;
  logic [WIDTH-1:0] r_key;
  logic [SW-1:0]  r_size;
  logic [EW-1:0]  r_elem;
  logic           r_pend;
  logic [EW-1:0]  r_pend_elem;
  logic [RW-1:0]  r_acc;
  logic           r_mem_rd;
  logic [AW-1:0]  r_mem_addr;
  logic           r_busy;
  logic           r_done;
  logic [RW-1:0]  r_result;

  logic [SW-1:0]    w_size_clamp;
  logic [AW-1:0]    w_base;
  logic [LANES-1:0] w_mask;
  logic [CW-1:0]    w_cnt;
  logic             w_any;
  logic [LW-1:0]    w_idx;
  logic [EW-1:0]    w_next_elem;
  logic [RW-1:0]    w_sum;
  logic [RW-1:0]    w_index;
  logic             w_consume;

  // launch-time operands: clamped size and array base address
  always_comb begin
    if (size > SW'(NAREA)) begin
      w_size_clamp = SW'(NAREA);
    end else begin
      w_size_clamp = size;
    end
    w_base = AW'(array) * AW'(NAREA);
  end

  // live-lane mask for the beat currently returning from the heap
  always_comb begin
    w_mask = '0;
    for (int k = 0; k < LANES; k++) begin
      w_mask[k] = (r_pend_elem + EW'(k)) < EW'(r_size);
    end
  end

  assign w_next_elem = r_elem + EW'(LANES);
  assign w_sum       = r_acc + RW'(w_cnt);
  assign w_index     = RW'(r_pend_elem) + RW'(w_idx) + RW'(1'b1);
  // returning data only counts while a scan is live; stale beats are dropped
  assign w_consume   = r_pend && ((r_state == READ) || (r_state == DRAIN));

  array_scan_lane_cmp #(
    .WIDTH (WIDTH),
    .LANES (LANES)
  ) u_cmp (
    .i_data  (mem_data),
    .i_valid (w_mask),
    .i_key   (r_key),
    .i_mode  (r_mode),
    .o_count (w_cnt),
    .o_any   (w_any),
    .o_first (w_idx)
  );

  // scan sequencer, address generator, accumulator and result register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_mode      <= INDEX;
      r_key       <= '0;
      r_size      <= '0;
      r_elem      <= '0;
      r_pend      <= 1'b0;
      r_pend_elem <= '0;
      r_acc       <= '0;
      r_mem_rd    <= 1'b0;
      r_mem_addr  <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_result    <= '0;
    end else begin
      r_done      <= 1'b0;
      r_pend      <= r_mem_rd;
      r_pend_elem <= r_elem;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_mode     <= scan_mode_t'(mode);
            r_key      <= key;
            r_size     <= w_size_clamp;
            r_acc      <= '0;
            r_elem     <= '0;
            r_mem_addr <= w_base;
            if (w_size_clamp == '0) begin
              r_state  <= FINISH;
              r_done   <= 1'b1;
              r_result <= '0;
            end else begin
              r_state  <= READ;
              r_mem_rd <= 1'b1;
              r_busy   <= 1'b1;
            end
          end
        end
        READ, DRAIN: begin
          if (w_consume && (r_mode == INDEX) && w_any) begin
            r_state  <= FINISH;
            r_mem_rd <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b1;
            r_result <= w_index;
          end else if (r_state == DRAIN) begin
            r_state  <= FINISH;
            r_busy   <= 1'b0;
            r_done   <= 1'b1;
            r_result <= (r_mode == INDEX) ? '0 : w_sum;
          end else begin
            if (w_consume) begin
              r_acc <= w_sum;
            end
            if (w_next_elem >= EW'(r_size)) begin
              r_mem_rd <= 1'b0;
              r_state  <= DRAIN;
            end else begin
              r_elem     <= w_next_elem;
              r_mem_addr <= r_mem_addr + AW'(LANES);
            end
          end
        end
        FINISH: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign mem_rd   = r_mem_rd;
  assign mem_addr = r_mem_addr;
  assign busy     = r_busy;
  assign done     = r_done;
  assign result   = r_result;

endmodule

// File: tb/tb_array_scan_unit.sv
// Directed bench for array_scan_unit: one LANES=1 and one LANES=2 instance
// sharing a registered heap model.
module tb_array_scan_unit;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        start1, start2;
  logic [1:0]  g_mode;
  logic [4:0]  g_array;
  logic [2:0]  g_size;
  logic [11:0] g_key;

  logic        rd1, rd2, busy1, busy2, done1, done2;
  logic [6:0]  addr1, addr2;
  logic [11:0] data1;
  logic [23:0] data2;
  logic [2:0]  res1, res2;

  logic [11:0] mem [0:127];

  int n_tests = 0;
  int n_fail  = 0;

  array_scan_unit #(.WIDTH(12), .NAREA(4), .NARRAYS(20), .LANES(1)) dut1 (
    .clock(clk), .reset(reset), .start(start1), .mode(g_mode), .array(g_array),
    .size(g_size), .key(g_key), .mem_rd(rd1), .mem_addr(addr1), .mem_data(data1),
    .busy(busy1), .done(done1), .result(res1)
  );

  array_scan_unit #(.WIDTH(12), .NAREA(4), .NARRAYS(20), .LANES(2)) dut2 (
    .clock(clk), .reset(reset), .start(start2), .mode(g_mode), .array(g_array),
    .size(g_size), .key(g_key), .mem_rd(rd2), .mem_addr(addr2), .mem_data(data2),
    .busy(busy2), .done(done2), .result(res2)
  );

  // heap model: data valid the cycle after the read strobe
  always @(posedge clk) begin
    if (rd1) data1 <= mem[addr1];
    if (rd2) data2 <= {mem[addr2 + 7'd1], mem[addr2]};
  end

  task automatic check_val(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Called #1 after a rising edge with the DUT idle; returns #1 after the
  // edge following the done cycle, so the next start is accepted.
  task automatic scan(input bit sel, input logic [1:0] m, input logic [4:0] arr,
                      input logic [2:0] sz, input logic [11:0] k, input int poke,
                      output int res, output int dcyc, output int nrd,
                      output int nbusy, output int a0, output int a1);
    g_mode = m; g_array = arr; g_size = sz; g_key = k;
    if (sel) start2 = 1'b1; else start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0; start2 = 1'b0;
    g_key = ~k; g_array = 5'd19; g_mode = ~m;
    res = -1; dcyc = -1; nrd = 0; nbusy = 0; a0 = -1; a1 = -1;
    for (int c = 1; c <= 40; c++) begin
      if (sel ? rd2 : rd1) begin
        if (nrd == 0) a0 = int'(sel ? addr2 : addr1);
        else if (nrd == 1) a1 = int'(sel ? addr2 : addr1);
        nrd++;
      end
      if (sel ? busy2 : busy1) nbusy++;
      if (sel ? done2 : done1) begin
        dcyc = c;
        res  = int'(sel ? res2 : res1);
        break;
      end
      if (c == poke) begin
        if (sel) start2 = 1'b1; else start1 = 1'b1;
        g_key = 12'hFFF; g_size = 3'd0; g_mode = 2'd0;
      end
      @(posedge clk); #1;
      start1 = 1'b0; start2 = 1'b0;
    end
    @(posedge clk); #1;
  endtask

  int t_mode [15] = '{0, 0, 0, 0, 1, 1, 1, 1, 2, 2, 2, 2, 3, 3, 1};
  int t_key  [15] = '{30, 20, 10, 15, 35, 25, 15, 5, 35, 25, 15, 5, 20, 1, 35};
  int t_size [15] = '{3, 3, 3, 3, 3, 3, 3, 3, 3, 3, 3, 3, 3, 3, 6};
  int t_res  [15] = '{3, 2, 1, 0, 3, 2, 1, 0, 0, 1, 2, 3, 1, 0, 4};
  int t_dcyc [15] = '{5, 4, 3, 5, 5, 5, 5, 5, 5, 5, 5, 5, 5, 5, 6};

  initial begin
    int r, dc, nrd, nb, a0, a1, quiet;
    for (int i = 0; i < 128; i++) mem[i] = 12'd0;
    mem[0] = 12'd10; mem[1] = 12'd20; mem[2] = 12'd30; mem[3] = 12'd1;
    mem[4] = 12'd5;  mem[5] = 12'd9;  mem[6] = 12'd9;  mem[7] = 12'd3;
    for (int i = 8; i < 12; i++) mem[i] = 12'd7;

    reset = 1'b1; start1 = 1'b0; start2 = 1'b0;
    g_mode = 2'd0; g_array = 5'd0; g_size = 3'd0; g_key = 12'd0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check_val("rst_rd",     int'(rd1),   0);
    check_val("rst_addr",   int'(addr1), 0);
    check_val("rst_busy",   int'(busy1), 0);
    check_val("rst_done",   int'(done1), 0);
    check_val("rst_result", int'(res1),  0);
    @(posedge clk); #1;

    for (int i = 0; i < 15; i++) begin
      scan(1'b0, 2'(t_mode[i]), 5'd0, 3'(t_size[i]), 12'(t_key[i]), 0,
           r, dc, nrd, nb, a0, a1);
      check_val($sformatf("res[%0d]", i),  r,  t_res[i]);
      check_val($sformatf("done[%0d]", i), dc, t_dcyc[i]);
      check_val($sformatf("busy[%0d]", i), nb, t_dcyc[i] - 1);
    end

    // live element 3 holds 1 and now counts
    scan(1'b0, 2'd1, 5'd0, 3'd4, 12'd5, 0, r, dc, nrd, nb, a0, a1);
    check_val("less_sz4_res", r, 1);

    scan(1'b0, 2'd2, 5'd0, 3'd0, 12'd0, 0, r, dc, nrd, nb, a0, a1);
    check_val("sz0_res",  r,   0);
    check_val("sz0_done", dc,  1);
    check_val("sz0_rd",   nrd, 0);
    check_val("sz0_busy", nb,  0);

    scan(1'b0, 2'd0, 5'd0, 3'd3, 12'd10, 0, r, dc, nrd, nb, a0, a1);
    check_val("idx_early_reads", nrd, 2);

    scan(1'b1, 2'd3, 5'd2, 3'd3, 12'd7, 0, r, dc, nrd, nb, a0, a1);
    check_val("l2_eq_res",  r,   3);
    check_val("l2_eq_done", dc,  4);
    check_val("l2_eq_nrd",  nrd, 2);
    check_val("l2_eq_a0",   a0,  8);
    check_val("l2_eq_a1",   a1,  10);

    scan(1'b1, 2'd0, 5'd1, 3'd4, 12'd9, 0, r, dc, nrd, nb, a0, a1);
    check_val("l2_idx9_res",  r,  2);
    check_val("l2_idx9_done", dc, 3);
    scan(1'b1, 2'd0, 5'd1, 3'd4, 12'd3, 0, r, dc, nrd, nb, a0, a1);
    check_val("l2_idx3_res",  r,  4);
    check_val("l2_idx3_done", dc, 4);
    scan(1'b1, 2'd0, 5'd1, 3'd3, 12'd3, 0, r, dc, nrd, nb, a0, a1);
    check_val("l2_idx3_mask_res",  r,  0);
    check_val("l2_idx3_mask_done", dc, 4);

    scan(1'b0, 2'd1, 5'd0, 3'd3, 12'd25, 2, r, dc, nrd, nb, a0, a1);
    check_val("poke_res",  r,  2);
    check_val("poke_done", dc, 5);
    quiet = 0;
    for (int c = 0; c < 4; c++) begin
      quiet += int'(busy1) + int'(done1) + int'(rd1);
      @(posedge clk); #1;
    end
    check_val("poke_no_restart", quiet, 0);
    check_val("poke_res_held", int'(res1), 2);

    g_mode = 2'd1; g_array = 5'd0; g_size = 3'd3; g_key = 12'd35;
    start1 = 1'b1;
    @(posedge clk); #1 start1 = 1'b0;
    @(posedge clk); #1;
    check_val("pre_rst_busy", int'(busy1), 1);
    reset = 1'b1;
    #1;
    check_val("mid_rst_rd",     int'(rd1),   0);
    check_val("mid_rst_addr",   int'(addr1), 0);
    check_val("mid_rst_busy",   int'(busy1), 0);
    check_val("mid_rst_done",   int'(done1), 0);
    check_val("mid_rst_result", int'(res1),  0);
    @(posedge clk); #1 reset = 1'b0;
    @(posedge clk); #1;
    scan(1'b0, 2'd1, 5'd0, 3'd3, 12'd25, 0, r, dc, nrd, nb, a0, a1);
    check_val("post_rst_res",  r,  2);
    check_val("post_rst_done", dc, 5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/array_scan_unit.md
# array_scan_unit

Multi-cycle array scan engine for the FPGA test machine. It executes the array-scan instruction family (index-of, count-less, count-greater and count-equal) against one array on the heap. It reads the heap through a single read port, `LANES` elements per beat, and honours the array's live size instead of scanning the whole area. The sequencer starts it with a start/done handshake and writes `result` back to local memory.

## Interface
- `WIDTH`, 12, memory element width in bits
- `NAREA`, 4, elements per heap area; must be a multiple of `LANES`
- `NARRAYS`, 20, maximum number of arrays
- `LANES`, 1, elements compared per beat; one of 1, 2, 4
- `clock` in 1: single clock; all state updates on its rising edge
- `reset` in 1: asynchronous, active-high; forces IDLE
- `start` in 1: request a scan; sampled only in IDLE
- `mode` in 2: 0 INDEX, 1 COUNT_LESS, 2 COUNT_GREATER, 3 COUNT_EQUAL
- `array` in $clog2(NARRAYS): array number
- `size` in $clog2(NAREA+1): live element count
- `key` in WIDTH: comparison value, unsigned
- `mem_rd` out 1: heap read strobe
- `mem_addr` out $clog2(NARRAYS*NAREA): element address of lane 0
- `mem_data` in LANES*WIDTH: lane k in bits [k*WIDTH +: WIDTH]; valid exactly one cycle after `mem_rd`
- `busy` out 1: high from the cycle after `start` is accepted until `done`
- `done` out 1: one-cycle pulse; `result` is valid in the same cycle
- `result` out $clog2(NAREA+1): scan result, held until the next accepted `start`

## Operation
- Launch: in IDLE with `start`=1, latch `mode`, `array` and `key`, plus `size` clamped to `NAREA`. Beats B = ceil(size/LANES). Clear the accumulator.
- States:
  - IDLE goes to READ on start when size > 0.
  - IDLE goes to FINISH on start when size = 0.
  - READ issues beat b at `mem_addr` = array*NAREA + b*LANES for b = 0..B-1, one beat per cycle, then goes to DRAIN.
  - DRAIN absorbs the last returning beat and goes to FINISH.
  - FINISH pulses `done` and returns to IDLE.
- Lane masking: element e = b*LANES + k is valid only if e < size. Invalid lanes never match or count.
- COUNT_LESS, COUNT_GREATER and COUNT_EQUAL: the accumulator adds the number of valid lanes with element <, > or == `key` respectively. Comparisons are unsigned.
- INDEX returns the 1-based position of the first match, or 0 if there is none.
  - On the first matching beat, take the lowest matching valid lane, stop issuing reads and go to FINISH.
  - Data for a beat already in flight is discarded.
- `result` width always covers NAREA; counts never overflow.
- `start` while `busy` is ignored and has no side effects.
- Reset, including mid-scan: `busy`=0, `done`=0, `result`=0, `mem_rd`=0, `mem_addr`=0, state IDLE. Data returning after reset is ignored.

## Timing
- Start accepted at edge 0.
- `mem_rd` is high in cycles 1..B. Data is consumed in cycles 2..B+1.
- Full scan: `done` in cycle B+2, so latency is B+2.
- size = 0: `done` in cycle 1 with `result`=0; no `mem_rd`.
- INDEX match on beat b (data in cycle b+2): `done` in cycle b+3. At most one extra read is issued after the matching beat.
- `busy` falls in the same cycle `done` rises. A new `start` is accepted in the `done` cycle + 1.
- Throughput: one beat per cycle, no bubbles between beats.

## Structure
- `array_scan_pkg` contains:
  - `scan_mode_t` enum (INDEX, COUNT_LESS, COUNT_GREATER, COUNT_EQUAL)
  - `scan_state_t` enum (IDLE, READ, DRAIN, FINISH)
  - width helper functions for address, size and result
- Sub-module `array_scan_lane_cmp` is purely combinational.
  - Inputs: one beat of data, the valid-lane mask, `key`, `mode`.
  - Outputs: the per-beat match count, the any-match flag and the lowest matching lane index.
- The top level holds the FSM, beat counter, address generator, accumulator and result register.

## Test plan
- Array 0 = {10,20,30,x}, size 3, LANES=1:
  - INDEX key 30, 20, 10, 15 gives `result` 3, 2, 1, 0.
  - Found cases finish early: INDEX key 10 gives `done` in cycle 3.
- Same array:
  - COUNT_LESS key 35, 25, 15, 5 gives 3, 2, 1, 0.
  - COUNT_GREATER key 35, 25, 15, 5 gives 0, 1, 2, 3.
  - COUNT_EQUAL key 20 gives 1.
  - Element 3 preloaded with 1 must never be counted.
- LANES=2, array 2 = {7,7,7,7}, size 3, COUNT_EQUAL key 7:
  - Gives 3.
  - `mem_addr` 8 then 10.
  - `done` in cycle 4.
- size=0, any mode: `done` in cycle 1, `result`=0, `mem_rd` never asserted. size=6 with NAREA=4 is clamped to 4.
- `start` pulsed while `busy`: ignored, and the first scan's result is unchanged.
- Reset asserted in cycle 2 of a scan:
  - All outputs go to 0 immediately.
  - A following scan returns the correct result.
